// File: rtl/vip_clock_ctrl_pkg.sv
// Shared types and reset defaults for the clock VIP
// waveform sequencer.
package vip_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int DEF_HIGH  = 1;
  localparam int DEF_LOW   = 1;
  localparam int DEF_BURST = 0;

endpackage

// File: rtl/vip_clock_ctrl_phase_cnt.sv
// Loadable phase down-counter; expire flags the last
// cycle of the current phase.
module vip_clock_ctrl_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/vip_clock_ctrl.sv
// Clock waveform sequencer: programmable high/low phases,
// free-running or N-period bursts, glitch-free stop.
module vip_clock_ctrl
  import vip_clock_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [CNT_W-1:0]   cfg_low,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               clk_oe,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [CNT_W-1:0]   high_q;
  logic [CNT_W-1:0]   low_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] rem_q;
  logic               stop_pend;

  logic [CNT_W-1:0]   high_c;
  logic [CNT_W-1:0]   low_c;
  logic [CNT_W-1:0]   eff_high;
  logic [BURST_W-1:0] eff_burst;
  logic [CNT_W-1:0]   load_val;
  logic               load;
  logic               expire;
  logic               cfg_take;
  logic               go;
  logic               finish;

  assign cfg_ready = (state == IDLE);
  assign cfg_take  = cfg_valid && (state == IDLE);
  assign go        = (state == IDLE) && start && !stop;

  assign high_c = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
  assign low_c  = (cfg_low == '0) ? CNT_W'(1) : cfg_low;

  // Config presented with start takes effect immediately.
  assign eff_high  = cfg_valid ? high_c : high_q;
  assign eff_burst = cfg_valid ? cfg_burst : burst_q;

  // rem_q is never zero in burst mode while running.
  assign finish = (state == LOW) && expire &&
                  (stop_pend || stop ||
                   (rem_q == BURST_W'(1)));

  always_comb begin
    load     = 1'b0;
    load_val = high_q;
    unique case (state)
      IDLE: begin
        load     = go;
        load_val = eff_high;
      end
      HIGH: begin
        load     = expire;
        load_val = low_q;
      end
      LOW: begin
        load     = expire && !finish;
        load_val = high_q;
      end
      default: begin
        load     = 1'b0;
        load_val = high_q;
      end
    endcase
  end

  vip_clock_ctrl_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .value  (load_val),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      high_q    <= CNT_W'(DEF_HIGH);
      low_q     <= CNT_W'(DEF_LOW);
      burst_q   <= BURST_W'(DEF_BURST);
      rem_q     <= '0;
      stop_pend <= 1'b0;
      clk_out   <= 1'b0;
      clk_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cfg_take) begin
        high_q  <= high_c;
        low_q   <= low_c;
        burst_q <= cfg_burst;
      end
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= HIGH;
            clk_out   <= 1'b1;
            clk_oe    <= 1'b1;
            busy      <= 1'b1;
            rem_q     <= eff_burst;
            stop_pend <= 1'b0;
          end
        end
        HIGH: begin
          if (stop) stop_pend <= 1'b1;
          if (expire) begin
            state   <= LOW;
            clk_out <= 1'b0;
          end
        end
        LOW: begin
          if (stop) stop_pend <= 1'b1;
          if (finish) begin
            state     <= IDLE;
            clk_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
          end else if (expire) begin
            state   <= HIGH;
            clk_out <= 1'b1;
            if (rem_q != '0) rem_q <= rem_q - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
          clk_oe  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vip_clock_ctrl.sv
// Directed bench for vip_clock_ctrl: vector table plus
// hand-written burst, stop, bypass and reset sequences.
module tb_vip_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_high = '0;
  logic [7:0]  cfg_low = '0;
  logic [15:0] cfg_burst = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clk_out;
  logic        clk_oe;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt;

  always #5 clk = ~clk;

  vip_clock_ctrl #(
    .CNT_W   (8),
    .BURST_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_high  (cfg_high),
    .cfg_low   (cfg_low),
    .cfg_burst (cfg_burst),
    .start     (start),
    .stop      (stop),
    .clk_out   (clk_out),
    .clk_oe    (clk_oe),
    .busy      (busy),
    .done      (done)
  );

  // {clk_out, clk_oe, busy, done, cfg_ready}
  typedef struct {
    logic        cv;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] bu;
    logic        st;
    logic        sp;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic cv, int hi, int lo,
                              int bu, logic st, logic sp,
                              logic [4:0] exp);
    vec_t v;
    v.cv  = cv;
    v.hi  = 8'(hi);
    v.lo  = 8'(lo);
    v.bu  = 16'(bu);
    v.st  = st;
    v.sp  = sp;
    v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [4:0] req);
    logic [4:0] act;
    act = {clk_out, clk_oe, busy, done, cfg_ready};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: out/oe/busy/done/rdy got %b want %b",
               name, act, req);
    end
  endtask

  task automatic idle_in();
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic set_cfg(int hi, int lo, int bu);
    cfg_valid = 1'b1;
    cfg_high  = 8'(hi);
    cfg_low   = 8'(lo);
    cfg_burst = 16'(bu);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5'b00001);
    tbl[1]  = mk(0, 0, 0, 0, 1, 0, 5'b11100);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 5'b01100);
    tbl[3]  = mk(1, 5, 5, 2, 0, 0, 5'b11100);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 5'b01100);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 5'b11100);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 5'b01100);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 5'b00011);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 5'b00001);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 5'b00001);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 5'b00001);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 5'b11100);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 5'b01100);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 5'b11100);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 5'b01100);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 5'b00011);

    // reset state
    tick();
    chk("reset_hold", 5'b00001);
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_release", 5'b00001);

    // burst 4 of high=2 low=3
    set_cfg(2, 3, 4);
    tick();
    chk("burst_cfg", 5'b00001);
    idle_in();
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("burst_c%0d", i),
          {((i % 5) < 2), 4'b1100});
    end
    tick();
    chk("burst_done", 5'b00011);
    tick();
    chk("burst_after", 5'b00001);

    // zero clamp, busy cfg, stop, start+stop
    for (int i = 0; i < 16; i++) begin
      cfg_valid = tbl[i].cv;
      cfg_high  = tbl[i].hi;
      cfg_low   = tbl[i].lo;
      cfg_burst = tbl[i].bu;
      start     = tbl[i].st;
      stop      = tbl[i].sp;
      tick();
      idle_in();
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // free-run 1/1, stop mid-HIGH of period 5
    set_cfg(1, 1, 0);
    tick();
    idle_in();
    done_cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) stop = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      if (done) done_cnt++;
      chk($sformatf("free_c%0d", c),
          {(c % 2 == 1), 4'b1100});
    end
    tick();
    if (done) done_cnt++;
    chk("free_done", 5'b00011);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("free_idle", 5'b00001);
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL free_done_count: got %0d want 1",
               done_cnt);
    end

    // cfg+start bypass, 3/1 burst 1
    set_cfg(3, 1, 1);
    start = 1'b1;
    tick();
    idle_in();
    chk("byp_c1", 5'b11100);
    tick();
    chk("byp_c2", 5'b11100);
    tick();
    chk("byp_c3", 5'b11100);
    tick();
    chk("byp_c4", 5'b01100);
    tick();
    chk("byp_done", 5'b00011);

    // async reset mid-LOW of burst 10
    set_cfg(2, 3, 10);
    start = 1'b1;
    tick();
    idle_in();
    chk("rst_c1", 5'b11100);
    tick();
    tick();
    tick();
    chk("rst_c4", 5'b01100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 5'b00001);
    tick();
    chk("rst_hold2", 5'b00001);
    rst_n = 1'b1;
    tick();
    chk("rst_nodone", 5'b00001);

    // defaults after reset: 1/1 free-running
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("def_c%0d", c),
          {(c % 2 == 1), 4'b1100});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("def_stop", 5'b01100);
    tick();
    chk("def_done", 5'b00011);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vip_clock_ctrl.md
Name: vip_clock_ctrl

Overview:
- Synthesizable clock-waveform sequencer for the clock VIP.
- Derives a programmable clock waveform `clk_out`, plus its output enable `clk_oe`, from the reference clock.
- Supports free-running and N-cycle burst modes, with glitch-free start/stop.
- `clk_out`/`clk_oe` feed the clock signal interface's driven value and active flag; the interface tri-states the line when `clk_oe`=0.

Parameters:
- CNT_W, 8, width of the high/low half-period counters (reference-clock cycles).
- BURST_W, 16, width of the burst length; 0 means free-running.

Ports:
- clk  in  1  reference clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration write strobe.
- cfg_ready  out  1  configuration accepted this cycle when high together with cfg_valid.
- cfg_high  in  CNT_W  high phase length in clk cycles.
- cfg_low  in  CNT_W  low phase length in clk cycles.
- cfg_burst  in  BURST_W  number of output periods; 0 = free-running.
- start  in  1  start request (level-sampled, single-cycle pulse expected).
- stop  in  1  stop request.
- clk_out  out  1  generated clock value.
- clk_oe  out  1  drive enable (agent active).
- busy  out  1  generator running (state != IDLE).
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: clk_out=0, clk_oe=0, busy=0, done=0, cfg_ready=1.
  - Internal: state=IDLE, high_q=1, low_q=1, burst_q=0, stop_pend=0.
- States:
  - IDLE: clk_out=0, clk_oe=0.
  - HIGH: clk_out=1, clk_oe=1.
  - LOW: clk_out=0, clk_oe=1.
  - All outputs are registered.
- cfg_ready = (state==IDLE).
  - cfg_valid is ignored outside IDLE.
  - Zero cfg_high/cfg_low are clamped to 1 on capture.
- IDLE→HIGH on start (and !stop):
  - Next cycle clk_out=1, clk_oe=1, busy=1.
  - Phase counter loads high_q and burst counter loads burst_q.
  - If cfg_valid and start coincide, the newly presented config is used (bypass).
- HIGH→LOW after exactly high_q cycles in HIGH.
- LOW lasts exactly low_q cycles. Output period = high_q+low_q cycles; duty = high_q/(high_q+low_q).
- End of LOW:
  - If stop_pend, or burst mode and remaining count hits 0: →IDLE, done=1 for one cycle, clk_oe drops in the same cycle as entering IDLE.
  - Otherwise →HIGH. Remaining count decrements once per completed period; it is unchanged in free-running mode.
- stop while in HIGH/LOW:
  - Sets stop_pend; the current period completes, so no runt pulses.
  - stop_pend clears on entering IDLE.
- stop in IDLE: no effect.
- start and stop together in IDLE: stop wins; stay IDLE.
- start while busy: ignored.
- Burst counter is BURST_W bits with no wrap. Free-running mode never decrements.
- Asynchronous reset mid-operation: outputs forced to reset values immediately, with no completion of the current period and no done pulse.

Decomposition:
- Package vip_clock_ctrl_pkg:
  - state enum {IDLE, HIGH, LOW} (2-bit).
  - Reset-default constants: DEF_HIGH=1, DEF_LOW=1, DEF_BURST=0.
- Sub-module vip_clock_ctrl_phase_cnt:
  - CNT_W-wide loadable down-counter with load, value, and an expire flag (count==1).
  - Instantiated once; it is reloaded at each phase boundary.

Test Plan:
- Reset, then cfg high=2, low=3, burst=4, then start:
  - clk_out pattern 11000 repeated exactly 4 times (20 cycles).
  - clk_oe=1 throughout, done pulse one cycle later, busy=0 afterwards.
- Free-running cfg high=1, low=1, burst=0; start; stop asserted mid-HIGH of period 5:
  - Period 5 completes (1 high, 1 low), then IDLE.
  - done=1 once; no pulse shorter than 1 cycle.
- cfg high=0, low=0:
  - Captured as 1/1; output toggles every cycle.
  - cfg_valid during busy: cfg_ready=0 and values unchanged.
- start and stop in the same IDLE cycle: state stays IDLE, clk_oe=0, no done.
- cfg_valid+start in the same cycle with high=3, low=1, burst=1: first period uses 3/1 (1110), then done.
- rst_n asserted mid-LOW of a burst=10 run:
  - Asynchronously clk_out=0, clk_oe=0, busy=0, no done.
  - After release: high_q=1, low_q=1, burst_q=0.
